sd_tx_fifo: RTL and testbench
=============================

Name: sd_tx_fifo

Overview:
Transmit-direction data FIFO for the SD controller. The host/DMA side pushes 32-bit words; the SD data-line serializer pops 4-bit nibbles, eight per word, in a fixed nibble order. It sits between the Wishbone/DMA master and the SD data TX state machine. It is the mirror of the nibble-to-word RX FIFO, on a single clock.

Parameters:
DEPTH, 8, number of 32-bit words stored; must be a power of two.
ADR_SIZE, 4, pointer width, equal to log2(DEPTH)+1; the MSB is the wrap bit.
BIG_ENDIAN, 1, 1 = first nibble out is d[31:28]; 0 = first nibble out is d[3:0].

Ports:
clk  input  1  single clock for both sides
rst  input  1  synchronous, active-high reset
d  input  32  word to push
wr  input  1  push request; sampled on the clk rising edge
full  output  1  no free word slot
clr  input  1  synchronous flush (block abort)
q  output  4  current head nibble (first-word fall-through)
rd  input  1  pop one nibble
empty  output  1  no unread word present
fill  output  ADR_SIZE  number of words held, counting a partially consumed word as held
nib_idx  output  3  index of the current nibble within the head word (0..7)

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- State: word RAM [DEPTH], write pointer adr_i, read pointer adr_o (ADR_SIZE bits each, MSB = wrap bit), nibble index nib_idx (3 bits).
- Reset (rst=1 at edge): adr_i=0, adr_o=0, nib_idx=0. Outputs after reset: empty=1, full=0, fill=0, nib_idx=0. RAM contents are not cleared; q is don't-care while empty.
- clr=1 at edge: same effect as reset on the pointers and nib_idx. clr takes priority over wr and rd in the same cycle.
- Push: when wr=1 and full=0, write ram[adr_i low bits] <= d and increment adr_i. When the low bits reach DEPTH-1, clear the low bits and toggle the wrap bit. When wr=1 and full=1, drop the write silently; no pointer change.
- Pop: when rd=1 and empty=0, nib_idx increments. When nib_idx==7, nib_idx returns to 0 and adr_o advances, with the same wrap rule as adr_i. When rd=1 and empty=1, ignore the read.
- q is combinational from ram[adr_o low bits] and nib_idx.
  - BIG_ENDIAN=1: q = word[31-4*nib_idx -: 4].
  - BIG_ENDIAN=0: q = word[4*nib_idx +: 4].
- Latency: a word written at edge N is visible at q and empty=0 after edge N (one cycle write-to-read).
- full = (low bits of adr_i == low bits of adr_o) AND (wrap bits differ).
- empty = (adr_i == adr_o).
- fill = adr_i - adr_o, modulo 2^ADR_SIZE.
- All flags are derived from pointers registered at the edge; no flag lookahead.
- Simultaneous wr and rd:
  - Both are evaluated against the pre-edge flags.
  - If full=1 and the pop consumes the last nibble of the head word, the write is still dropped that cycle.
  - If empty=0 and not full, the push and pop both take effect.
- Wrap-around: the pointers wrap after DEPTH words. The wrap-bit toggle keeps full and empty unambiguous across any number of wraps.
- No partial-word push; every push supplies all 8 nibbles.

Decomposition:
- Shared package/defines (sd_defines.v): FIFO_TX_MEM_DEPTH and FIFO_TX_MEM_ADR_SIZE defaults, which feed DEPTH and ADR_SIZE.
- One sub-module is natural: sd_fifo_ptr, the wrap-bit pointer incrementer with a clr input. It is instantiated twice, for adr_i and adr_o.
- The RAM stays inline.

Test Plan:
- Reset then push 32'h1234_5678, BIG_ENDIAN=1 -> empty falls the next cycle; 8 consecutive rd give q = 1,2,3,4,5,6,7,8; empty=1 after the 8th pop; fill goes 1 then 0.
- Same stimulus with BIG_ENDIAN=0 -> q sequence 8,7,6,5,4,3,2,1.
- Push 8 words 32'hA000_0000+i with no reads -> full=1 and fill=8. A 9th push 32'hDEAD_BEEF is dropped; popping all 64 nibbles returns only the A-words in order and never BEEF.
- Fill to full, then assert wr=1 with 32'hCAFE_F00D and rd=1 on nib_idx=7 of the head word, in the same cycle -> write dropped, fill=7. A push on the next cycle succeeds and fill=8.
- Run 3 full wrap cycles of 8 words each with interleaved reads -> data order preserved and fill consistent at every cycle; full and empty never both 1.
- Push 2 words, pop 3 nibbles (nib_idx=3), then pulse clr -> empty=1, fill=0, nib_idx=0. Next push 32'h0F0F_0F0F with BIG_ENDIAN=1 yields q=0 first.
- Repeat the same mid-stream case with rst instead of clr -> identical response.

Source files
------------

// File: rtl/sd_tx_fifo_pkg.sv
// Shared defaults for the SD transmit FIFO.
// Depth and pointer width feed the FIFO parameters.
package sd_tx_fifo_pkg;
  localparam int FIFO_TX_MEM_DEPTH    = 8;
  localparam int FIFO_TX_MEM_ADR_SIZE = 4;
  localparam int NIBS_PER_WORD        = 8;
endpackage

// File: rtl/sd_tx_fifo_ptr.sv
// Wrap-bit pointer: plain binary increment of an ADR_SIZE-bit
// counter toggles the MSB exactly when the low bits roll over.
module sd_tx_fifo_ptr
  import sd_tx_fifo_pkg::*;
#(
  parameter int ADR_SIZE = FIFO_TX_MEM_ADR_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [ADR_SIZE-1:0] ptr_o
);

  logic [ADR_SIZE-1:0] ptr_q;
  logic [ADR_SIZE-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i)
      ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sd_tx_fifo.sv
// Word-in, nibble-out transmit FIFO for the SD data lines.
// Head word falls through; nibble order set by BIG_ENDIAN.
module sd_tx_fifo
  import sd_tx_fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_TX_MEM_DEPTH,
  parameter int ADR_SIZE   = FIFO_TX_MEM_ADR_SIZE,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         d,
  input  logic                wr,
  output logic                full,
  input  logic                clr,
  output logic [3:0]          q,
  input  logic                rd,
  output logic                empty,
  output logic [ADR_SIZE-1:0] fill,
  output logic [2:0]          nib_idx
);

  localparam int LW = ADR_SIZE - 1;

  logic [31:0]         ram_q [DEPTH];
  logic [ADR_SIZE-1:0] adr_i_q;
  logic [ADR_SIZE-1:0] adr_o_q;
  logic [2:0]          nib_q;
  logic [2:0]          nib_d;
  logic                push;
  logic                pop;
  logic                word_done;
  logic [31:0]         head;
  logic [4:0]          shamt;
  logic [31:0]         head_sh;

  // clr wins over both sides, so neither side may act in that cycle
  assign push      = wr & ~full & ~clr;
  assign pop       = rd & ~empty & ~clr;
  assign word_done = pop & (nib_q == 3'd7);

  sd_tx_fifo_ptr #(.ADR_SIZE(ADR_SIZE)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (push),
    .ptr_o (adr_i_q)
  );

  sd_tx_fifo_ptr #(.ADR_SIZE(ADR_SIZE)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (word_done),
    .ptr_o (adr_o_q)
  );

  always_ff @(posedge clk) begin
    if (push)
      ram_q[adr_i_q[LW-1:0]] <= d;
  end

  always_comb begin
    nib_d = nib_q;
    if (pop)
      nib_d = nib_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)
      nib_q <= '0;
    else
      nib_q <= nib_d;
  end

  assign head    = ram_q[adr_o_q[LW-1:0]];
  assign shamt   = (BIG_ENDIAN != 0) ? {~nib_q, 2'b00}
                                     : { nib_q, 2'b00};
  assign head_sh = head >> shamt;
  assign q       = head_sh[3:0];

  assign empty   = (adr_i_q == adr_o_q);
  assign full    = (adr_i_q[LW-1:0] == adr_o_q[LW-1:0]) &
                   (adr_i_q[LW] != adr_o_q[LW]);
  assign fill    = adr_i_q - adr_o_q;
  assign nib_idx = nib_q;

endmodule

// File: tb/tb_sd_tx_fifo.sv
// Bench for sd_tx_fifo: directed and random traffic against
// a word-queue model, both nibble orders side by side.
module tb_sd_tx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   d   = '0;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic          clr = 1'b0;
  logic          full_b, empty_b, full_l, empty_l;
  logic [3:0]    q_b, q_l;
  logic [AW-1:0] fill_b, fill_l;
  logic [2:0]    nib_b, nib_l;

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];
  int          mnib = 0;

  always #5 clk = ~clk;

  sd_tx_fifo #(.DEPTH(DEPTH), .ADR_SIZE(AW), .BIG_ENDIAN(1)) u_be (
    .clk(clk), .rst(rst), .d(d), .wr(wr), .full(full_b),
    .clr(clr), .q(q_b), .rd(rd), .empty(empty_b),
    .fill(fill_b), .nib_idx(nib_b)
  );

  sd_tx_fifo #(.DEPTH(DEPTH), .ADR_SIZE(AW), .BIG_ENDIAN(0)) u_le (
    .clk(clk), .rst(rst), .d(d), .wr(wr), .full(full_l),
    .clr(clr), .q(q_l), .rd(rd), .empty(empty_l),
    .fill(fill_l), .nib_idx(nib_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] w;
    int sz;
    sz = mq.size();
    chk("empty_be", 32'(empty_b), 32'(sz == 0));
    chk("empty_le", 32'(empty_l), 32'(sz == 0));
    chk("full_be", 32'(full_b), 32'(sz == DEPTH));
    chk("full_le", 32'(full_l), 32'(sz == DEPTH));
    chk("fill_be", 32'(fill_b), 32'(sz));
    chk("fill_le", 32'(fill_l), 32'(sz));
    chk("nib_be", 32'(nib_b), 32'(mnib));
    chk("nib_le", 32'(nib_l), 32'(mnib));
    chk("not_full_and_empty", 32'(full_b & empty_b), 32'd0);
    if (sz > 0) begin
      w = mq[0];
      chk("q_be", 32'(q_b), (w >> (4 * (7 - mnib))) & 32'hF);
      chk("q_le", 32'(q_l), (w >> (4 * mnib)) & 32'hF);
    end
  endtask

  task automatic cyc(input logic w_i, input logic [31:0] d_i,
                     input logic r_i, input logic c_i,
                     input logic rs_i);
    bit push_ok, pop_ok;
    wr = w_i; d = d_i; rd = r_i; clr = c_i; rst = rs_i;
    push_ok = w_i && (mq.size() < DEPTH);
    pop_ok  = r_i && (mq.size() > 0);
    @(posedge clk);
    if (rs_i || c_i) begin
      mq.delete();
      mnib = 0;
    end else begin
      if (pop_ok) begin
        mnib++;
        if (mnib == 8) begin
          mnib = 0;
          void'(mq.pop_front());
        end
      end
      if (push_ok) mq.push_back(d_i);
    end
    #1;
    wr = 0; rd = 0; clr = 0; rst = 0;
    check_model();
  endtask

  task automatic push(input logic [31:0] v);
    cyc(1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 32'(empty_b), 32'd1);
    chk("rst_fill", 32'(fill_b), 32'd0);

    push(32'h1234_5678);
    chk("first_q_be", 32'(q_b), 32'h1);
    chk("first_q_le", 32'(q_l), 32'h8);
    chk("fill_one", 32'(fill_b), 32'd1);
    pop(7);
    chk("last_q_be", 32'(q_b), 32'h8);
    chk("last_q_le", 32'(q_l), 32'h1);
    pop(1);
    chk("drained", 32'(empty_b), 32'd1);

    for (int i = 0; i < 8; i++) push(32'hA000_0000 + 32'(i));
    chk("full8", 32'(full_b), 32'd1);
    chk("fill8", 32'(fill_b), 32'd8);
    push(32'hDEAD_BEEF);
    chk("drop_fill", 32'(fill_b), 32'd8);
    pop(64);
    chk("drained64", 32'(empty_b), 32'd1);

    for (int i = 0; i < 8; i++) push(32'hB000_0000 + 32'(i));
    pop(7);
    cyc(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    chk("simul_fill7", 32'(fill_b), 32'd7);
    push(32'hC000_0001);
    chk("refill8", 32'(fill_b), 32'd8);
    pop(64);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 2) != 0), $urandom,
          1'($urandom_range(0, 1)), 1'b0, 1'b0);
    pop(70);

    push(32'h1111_1111);
    push(32'h2222_2222);
    pop(3);
    chk("mid_nib3", 32'(nib_b), 32'd3);
    cyc(1'b1, 32'h3333_3333, 1'b1, 1'b1, 1'b0);
    chk("clr_empty", 32'(empty_b), 32'd1);
    chk("clr_fill", 32'(fill_b), 32'd0);
    chk("clr_nib", 32'(nib_b), 32'd0);
    push(32'h0F0F_0F0F);
    chk("clr_q0", 32'(q_b), 32'h0);
    pop(8);

    push(32'h4444_4444);
    push(32'h5555_5555);
    pop(3);
    cyc(1'b1, 32'h6666_6666, 1'b1, 1'b0, 1'b1);
    chk("rst_empty2", 32'(empty_b), 32'd1);
    chk("rst_fill2", 32'(fill_b), 32'd0);
    chk("rst_nib2", 32'(nib_b), 32'd0);
    push(32'h0F0F_0F0F);
    chk("rst_q0", 32'(q_b), 32'h0);
    chk("rst_q0_le", 32'(q_l), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
